// File: rtl/sdram_burst_arbiter.sv
// -----------------------------------------------------------------------------
// sdram_burst_arbiter
//
// Shares the single full-page burst port of sdram_controller among NUM_REQ
// requesters (camera write, VGA read, spare). Each requester posts one
// 512-word page burst (direction + page address). The arbiter grants one
// requester at a time in round-robin order and issues rw/rw_en/f_addr for the
// granted burst. It routes the controller's data strobes and the write data
// between the controller and the current owner. Runs in the SDRAM clock
// domain.
//
// Optional feature macro: URGENT_PRIO_EN
//   defined   : requests flagged urgent win arbitration over non-urgent ones
//               (round-robin among urgent requests, same pointer update).
//   undefined : urgent input is ignored; pure round-robin.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   req             per-requester burst request (level, held until done)
//   req_rw          per-requester direction, 1 read / 0 write
//   req_addr        per-requester page address, packed NUM_REQ*ADDR_W
//   req_wdata       per-requester write data, packed NUM_REQ*DATA_W
//   urgent          per-requester urgent flag
//   grant           one-hot owner of the current burst
//   done            one-cycle pulse when the owner's burst completes
//   wr_strobe       f2s_data_valid routed to the owner
//   rd_strobe       s2f_data_valid routed to the owner
//   timeout_err     sticky: the controller never accepted a command
//   rw, rw_en       command direction and one-cycle command strobe
//   f_addr          command page address
//   f2s_data        owner's write data to the controller
//   ready           controller idle/available
//   f2s_data_valid  controller consumes a write word
//   s2f_data_valid  controller presents a read word
// -----------------------------------------------------------------------------
module sdram_burst_arbiter #(
  parameter int NUM_REQ     = 3,
  parameter int ADDR_W      = 15,
  parameter int DATA_W      = 16,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_rw,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  input  logic [NUM_REQ-1:0]        urgent,
  output logic [NUM_REQ-1:0]        grant,
  output logic [NUM_REQ-1:0]        done,
  output logic [NUM_REQ-1:0]        wr_strobe,
  output logic [NUM_REQ-1:0]        rd_strobe,
  output logic                      timeout_err,
  output logic                      rw,
  output logic                      rw_en,
  output logic [ADDR_W-1:0]         f_addr,
  output logic [DATA_W-1:0]         f2s_data,
  input  logic                      ready,
  input  logic                      f2s_data_valid,
  input  logic                      s2f_data_valid
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_ACK  = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  state_t               state_q,       state_d;
  logic [NUM_REQ-1:0]   grant_q,       grant_d;
  logic [NUM_REQ-1:0]   done_q,        done_d;
  logic                 rw_q,          rw_d;
  logic                 rw_en_q,       rw_en_d;
  logic [ADDR_W-1:0]    f_addr_q,      f_addr_d;
  logic                 timeout_err_q, timeout_err_d;
  logic [PTR_W-1:0]     rr_ptr_q,      rr_ptr_d;
  logic [CNT_W-1:0]     ack_cnt_q,     ack_cnt_d;

  logic [NUM_REQ-1:0]   cand;
  logic [NUM_REQ-1:0]   winner;
  logic [ADDR_W-1:0]    winner_addr;
  logic                 winner_rw;

  // First set bit of v at or above ptr, else first set bit below ptr
  // (i.e. a scan from ptr upward with wrap-around), returned one-hot.
  function automatic logic [NUM_REQ-1:0] rr_pick(
    input logic [NUM_REQ-1:0] v,
    input logic [PTR_W-1:0]   ptr
  );
    logic [NUM_REQ-1:0] oh;
    logic               found;
    oh    = '0;
    found = 1'b0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!found && v[j] && (j >= int'(ptr))) begin
        oh[j] = 1'b1;
        found = 1'b1;
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!found && v[j] && (j < int'(ptr))) begin
        oh[j] = 1'b1;
        found = 1'b1;
      end
    end
    return oh;
  endfunction

  // Pointer value just past the one-hot owner, modulo NUM_REQ.
  function automatic logic [PTR_W-1:0] ptr_after(input logic [NUM_REQ-1:0] oh);
    logic [PTR_W-1:0] p;
    p = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (oh[i]) begin
        p = (i == NUM_REQ - 1) ? '0 : PTR_W'(i + 1);
      end
    end
    return p;
  endfunction

`ifdef URGENT_PRIO_EN
  // Urgent requests form the candidate set whenever any is present.
  always_comb begin
    cand = req;
    if (|(req & urgent)) begin
      cand = req & urgent;
    end
  end
`else
  logic unused_urgent;
  assign cand          = req;
  assign unused_urgent = ^urgent;
`endif

  assign winner    = rr_pick(cand, rr_ptr_q);
  assign winner_rw = |(req_rw & winner);

  always_comb begin
    winner_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner[i]) begin
        winner_addr = winner_addr | req_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    done_d        = '0;
    rw_d          = rw_q;
    rw_en_d       = 1'b0;
    f_addr_d      = f_addr_q;
    timeout_err_d = timeout_err_q;
    rr_ptr_d      = rr_ptr_q;
    ack_cnt_d     = ack_cnt_q;

    case (state_q)
      S_IDLE: begin
        if ((|req) && ready) begin
          grant_d  = winner;
          rw_d     = winner_rw;
          f_addr_d = winner_addr;
          state_d  = S_ISSUE;
        end
      end

      S_ISSUE: begin
        rw_en_d   = 1'b1;
        ack_cnt_d = '0;
        state_d   = S_WAIT_ACK;
      end

      S_WAIT_ACK: begin
        if (!ready) begin
          state_d = S_WAIT_DONE;
        end else if (ack_cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
          // Controller never took the command: drop the burst, release the
          // owner and move the pointer on so a stuck requester cannot starve
          // the others.
          timeout_err_d = 1'b1;
          done_d        = grant_q;
          grant_d       = '0;
          rr_ptr_d      = ptr_after(grant_q);
          state_d       = S_IDLE;
        end else begin
          ack_cnt_d = ack_cnt_q + 1'b1;
        end
      end

      S_WAIT_DONE: begin
        if (ready) begin
          done_d   = grant_q;
          grant_d  = '0;
          rr_ptr_d = ptr_after(grant_q);
          state_d  = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      grant_q       <= '0;
      done_q        <= '0;
      rw_q          <= 1'b0;
      rw_en_q       <= 1'b0;
      f_addr_q      <= '0;
      timeout_err_q <= 1'b0;
      rr_ptr_q      <= '0;
      ack_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      done_q        <= done_d;
      rw_q          <= rw_d;
      rw_en_q       <= rw_en_d;
      f_addr_q      <= f_addr_d;
      timeout_err_q <= timeout_err_d;
      rr_ptr_q      <= rr_ptr_d;
      ack_cnt_q     <= ack_cnt_d;
    end
  end

  // Data-path steering: combinational so the owner sees strobes in the same
  // cycle the controller raises them; with no owner everything reads zero.
  always_comb begin
    f2s_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) begin
        f2s_data = f2s_data | req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign wr_strobe   = {NUM_REQ{f2s_data_valid}} & grant_q;
  assign rd_strobe   = {NUM_REQ{s2f_data_valid}} & grant_q;

  assign grant       = grant_q;
  assign done        = done_q;
  assign rw          = rw_q;
  assign rw_en       = rw_en_q;
  assign f_addr      = f_addr_q;
  assign timeout_err = timeout_err_q;

endmodule
